// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU command sequencer and its FIFO.
package alu_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned IN_SEL_W   = 3;
  localparam int unsigned OUT_SEL_W  = 7;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    ALU_OFF       = 2'b00,
    ALU_READY     = 2'b01,
    ALU_RUN       = 2'b10,
    ALU_RUN_ERROR = 2'b11
  } alu_state_e;

  localparam logic [IN_SEL_W-1:0] IN_SEL_PERSIST = 3'b100;
  localparam logic [IN_SEL_W-1:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [IN_SEL_W-1:0] IN_SEL_RESET   = 3'b001;

  typedef enum logic [OP_W-1:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_NOT     = 3'd2,
    OP_XOR     = 3'd3,
    OP_ADD     = 3'd4,
    OP_SUB     = 3'd5,
    OP_MUL     = 3'd6,
    OP_ILLEGAL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_RESP  = 2'd3
  } seq_state_e;

  typedef struct packed {
    alu_op_e             op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                chain;
  } alu_cmd_t;

  // One-hot output selector for a legal opcode; bit 0 is AND.
  function automatic logic [OUT_SEL_W-1:0] op_onehot(input alu_op_e op);
    return OUT_SEL_W'(1) << op;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response handshake bundle between host and sequencer.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OP_W-1:0]     cmd_op;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;
  logic                cmd_chain;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// 2-deep first-word-fall-through command FIFO with a registered ready flag.
module alu_cmd_fifo
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  alu_cmd_t         i_data,
  output alu_cmd_t         o_head_c,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_nxt_c,
  output logic             o_ready
);

  alu_cmd_t         r_mem [FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(i_pop);

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Ready looks at the next count so a push into the last slot closes it at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  assign o_head_c      = r_mem[r_rd_ptr];
  assign o_count       = r_count;
  assign o_count_nxt_c = w_count_nxt;
  assign o_ready       = r_ready;

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven initiator for the 8-bit ALU: queues commands, drives ALU
// controls, captures result and error state, and returns a response.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter bit ACC_CHAIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_sequencer_if.slave       cmd_if,
  output logic                 o_alu_on,
  output logic [IN_SEL_W-1:0]  o_alu_in_sel,
  output logic [DATA_W-1:0]    o_alu_num1,
  output logic [DATA_W-1:0]    o_alu_num2,
  output logic [OUT_SEL_W-1:0] o_alu_out_sel,
  input  logic [DATA_W-1:0]    i_alu_result,
  input  logic [1:0]           i_alu_state,
  output logic                 o_busy
);

  seq_state_e           r_state;
  logic                 r_alu_on;
  logic                 r_busy;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic [DATA_W-1:0]    r_rsp_data;
  logic [DATA_W-1:0]    r_acc;
  logic                 r_acc_vld;
  logic [IN_SEL_W-1:0]  r_in_sel;
  logic [OUT_SEL_W-1:0] r_out_sel;
  logic [DATA_W-1:0]    r_num1;
  logic [DATA_W-1:0]    r_num2;

  alu_cmd_t             w_cmd_in;
  alu_cmd_t             w_head;
  logic [CNT_W-1:0]     w_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_fifo_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_chain;
  logic                 w_bypass;
  logic                 w_rsp_fire;

  assign w_cmd_in = '{op:    alu_op_e'(cmd_if.cmd_op),
                      a:     cmd_if.cmd_a,
                      b:     cmd_if.cmd_b,
                      chain: cmd_if.cmd_chain};

  assign w_push     = cmd_if.cmd_valid && w_fifo_ready;
  assign w_pop      = (r_state == SEQ_IDLE) && (w_count != '0);
  assign w_chain    = ACC_CHAIN && w_head.chain;
  assign w_bypass   = (w_head.op == OP_ILLEGAL) || (w_chain && !r_acc_vld);
  assign w_rsp_fire = r_rsp_valid && cmd_if.rsp_ready;

  alu_cmd_fifo u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_data        (w_cmd_in),
    .o_head_c      (w_head),
    .o_count       (w_count),
    .o_count_nxt_c (w_count_nxt),
    .o_ready       (w_fifo_ready)
  );

  // Sequencer FSM; every ALU control and response output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SEQ_IDLE;
      r_alu_on    <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_acc       <= '0;
      r_acc_vld   <= 1'b0;
      r_in_sel    <= IN_SEL_RESET;
      r_out_sel   <= op_onehot(OP_AND);
      r_num1      <= '0;
      r_num2      <= '0;
    end else begin
      if (w_push) r_alu_on <= 1'b1;
      r_busy <= (w_count_nxt != '0);
      case (r_state)
        SEQ_IDLE: begin
          if (w_pop) begin
            r_busy <= 1'b1;
            if (w_bypass) begin
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= SEQ_RESP;
            end else begin
              r_in_sel  <= IN_SEL_LOAD;
              r_num1    <= w_chain ? r_acc : w_head.a;
              r_num2    <= w_head.b;
              r_out_sel <= op_onehot(w_head.op);
              r_state   <= SEQ_ISSUE;
            end
          end
        end
        SEQ_ISSUE: begin
          r_busy  <= 1'b1;
          r_state <= SEQ_WAIT;
        end
        SEQ_WAIT: begin
          // ALU registers were loaded on the ISSUE edge; the result is stable now.
          r_busy      <= 1'b1;
          r_rsp_data  <= i_alu_result;
          r_rsp_err   <= (alu_state_e'(i_alu_state) == ALU_RUN_ERROR);
          r_acc       <= i_alu_result;
          r_acc_vld   <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_in_sel    <= IN_SEL_RESET;
          r_out_sel   <= op_onehot(OP_AND);
          r_num1      <= '0;
          r_num2      <= '0;
          r_state     <= SEQ_RESP;
        end
        SEQ_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_state     <= SEQ_IDLE;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign cmd_if.cmd_ready = w_fifo_ready;
  assign cmd_if.rsp_valid = r_rsp_valid;
  assign cmd_if.rsp_data  = r_rsp_data;
  assign cmd_if.rsp_err   = r_rsp_err;
  assign o_alu_on         = r_alu_on;
  assign o_alu_in_sel     = r_in_sel;
  assign o_alu_num1       = r_num1;
  assign o_alu_num2       = r_num2;
  assign o_alu_out_sel    = r_out_sel;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small behavioural ALU.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_result;
  logic [1:0] alu_state;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer #(.ACC_CHAIN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_if        (bus),
    .o_alu_on      (alu_on),
    .o_alu_in_sel  (alu_in_sel),
    .o_alu_num1    (alu_num1),
    .o_alu_num2    (alu_num2),
    .o_alu_out_sel (alu_out_sel),
    .i_alu_result  (alu_result),
    .i_alu_state   (alu_state),
    .o_busy        (busy)
  );

  // Behavioural ALU: operand registers, combinational result, error on carry-out.
  logic [7:0]  m_r1;
  logic [7:0]  m_r2;
  logic [15:0] m_wide;

  always_ff @(posedge clk) begin
    if (rst || alu_in_sel == 3'b001) begin
      m_r1 <= 8'h00;
      m_r2 <= 8'h00;
    end else if (alu_in_sel == 3'b010) begin
      m_r1 <= alu_num1;
      m_r2 <= alu_num2;
    end
  end

  always_comb begin
    m_wide = 16'h0000;
    case (alu_out_sel)
      7'h01: m_wide = {8'h00, m_r1 & m_r2};
      7'h02: m_wide = {8'h00, m_r1 | m_r2};
      7'h04: m_wide = {8'h00, ~m_r1};
      7'h08: m_wide = {8'h00, m_r1 ^ m_r2};
      7'h10: m_wide = 16'(m_r1) + 16'(m_r2);
      7'h20: m_wide = 16'(m_r1) - 16'(m_r2);
      7'h40: m_wide = 16'(m_r1) * 16'(m_r2);
      default: m_wide = 16'h0000;
    endcase
    alu_result = m_wide[7:0];
    alu_state  = (m_wide[15:8] != 8'h00) ? 2'b11 : (alu_on ? 2'b10 : 2'b00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one command with rsp_ready high, then check latency and response.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ch, input logic [7:0] exp_d,
                         input logic exp_e, input int exp_lat,
                         output logic [2:0] isel_or, output logic [6:0] osel_or);
    int acc_cyc;
    int k;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_chain = ch;
    bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      tick();
      k++;
    end
    acc_cyc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    isel_or = 3'b000;
    osel_or = 7'h00;
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      isel_or = isel_or | alu_in_sel;
      osel_or = osel_or | alu_out_sel;
      tick();
      k++;
    end
    check({tag, "_lat"},  32'(cyc - acc_cyc), 32'(exp_lat));
    check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
    check({tag, "_err"},  32'(bus.rsp_err),  32'(exp_e));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] isel;
    logic [6:0] osel;
    logic [7:0] bp_exp [4];
    int         n_rsp;
    int         k;
    logic       acc_now;
    logic       c3_acc;
    logic       seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.cmd_chain = 1'b0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_alu_on",    32'(alu_on),        32'd0);
    check("rst_in_sel",    32'(alu_in_sel),    32'h1);
    check("rst_out_sel",   32'(alu_out_sel),   32'h01);
    check("rst_num1",      32'(alu_num1),      32'd0);
    check("rst_num2",      32'(alu_num2),      32'd0);

    // Chain with no accumulator yet: bypass error, ALU untouched.
    run_cmd("chain_rst", 3'd4, 8'h55, 8'h01, 1'b1, 8'h00, 1'b1, 2, isel, osel);
    check("chain_rst_in_sel",  32'(isel), 32'h1);
    check("chain_rst_out_sel", 32'(osel), 32'h01);
    check("alu_on_set",        32'(alu_on), 32'd1);

    run_cmd("add", 3'd4, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 4, isel, osel);
    check("add_in_sel",  32'(isel), 32'h3);
    check("add_out_sel", 32'(osel), 32'h11);

    run_cmd("add53",     3'd4, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 4, isel, osel);
    run_cmd("chain_sub", 3'd5, 8'hEE, 8'h02, 1'b1, 8'h06, 1'b0, 4, isel, osel);
    check("chain_sub_out_sel", 32'(osel), 32'h21);

    // Overflowing MUL still updates the accumulator (0x200 -> 0x00).
    run_cmd("mul_ovf",   3'd6, 8'h20, 8'h10, 1'b0, 8'h00, 1'b1, 4, isel, osel);
    run_cmd("chain_add", 3'd4, 8'hFF, 8'h07, 1'b1, 8'h07, 1'b0, 4, isel, osel);

    run_cmd("illegal", 3'd7, 8'h01, 8'h02, 1'b0, 8'h00, 1'b1, 2, isel, osel);
    check("illegal_out_sel", 32'(osel), 32'h01);
    check("illegal_in_sel",  32'(isel), 32'h1);

    // Backpressure: stall one response, fill the FIFO, then drain in order.
    bp_exp[0] = 8'h30;
    bp_exp[1] = 8'hFF;
    bp_exp[2] = 8'h55;
    bp_exp[3] = 8'hF0;
    bus.rsp_ready = 1'b0;
    bus.cmd_op = 3'd0; bus.cmd_a = 8'hF0; bus.cmd_b = 8'h3C; bus.cmd_chain = 1'b0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("bp_stall_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_hold_data",   32'(bus.rsp_data),  32'h30);
    bus.cmd_op = 3'd1; bus.cmd_a = 8'hF0; bus.cmd_b = 8'h0F;
    check("bp_ready_c1", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_op = 3'd3; bus.cmd_a = 8'hAA; bus.cmd_b = 8'hFF;
    check("bp_ready_c2", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_op = 3'd2; bus.cmd_a = 8'h0F; bus.cmd_b = 8'h99;
    check("bp_ready_c3", 32'(bus.cmd_ready), 32'd0);
    check("bp_busy",     32'(busy),          32'd1);
    bus.rsp_ready = 1'b1;
    n_rsp  = 0;
    c3_acc = 1'b0;
    for (int i = 0; i < 60 && n_rsp < 4; i++) begin
      acc_now = bus.cmd_valid && bus.cmd_ready;
      if (bus.rsp_valid) begin
        check($sformatf("bp_data%0d", n_rsp), 32'(bus.rsp_data), 32'(bp_exp[n_rsp]));
        check($sformatf("bp_err%0d", n_rsp),  32'(bus.rsp_err),  32'd0);
        n_rsp++;
      end
      tick();
      if (acc_now) begin
        bus.cmd_valid = 1'b0;
        c3_acc = 1'b1;
      end
    end
    bus.cmd_valid = 1'b0;
    check("bp_rsp_count",   32'(n_rsp),  32'd4);
    check("bp_c3_accepted", 32'(c3_acc), 32'd1);

    // Reset while the first command sits in WAIT and a second is queued.
    bus.cmd_op = 3'd4; bus.cmd_a = 8'h01; bus.cmd_b = 8'h01; bus.cmd_chain = 1'b0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_a = 8'h02; bus.cmd_b = 8'h02;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mrst_busy",      32'(busy),          32'd0);
    check("mrst_alu_on",    32'(alu_on),        32'd0);
    check("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("mrst_in_sel",    32'(alu_in_sel),    32'h1);
    check("mrst_out_sel",   32'(alu_out_sel),   32'h01);
    seen = 1'b0;
    repeat (8) begin
      if (bus.rsp_valid) seen = 1'b1;
      tick();
    end
    check("mrst_no_rsp",     32'(seen), 32'd0);
    check("mrst_busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
